// File: rtl/crc_64_rx_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : crc_64_rx_buf                                                |
// | Description : Receive buffer and error monitor behind the CRC-6 codeword   |
// |               decoder. Error-free words go into a first-word-fall-through  |
// |               FIFO with a valid/ready output. Errored words are discarded  |
// |               and counted. A run of ERR_BURST consecutive errored words    |
// |               raises a single-cycle retransmit request.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, reset_n            clock, asynchronous active-low reset             |
// |   in_valid/in_data/       decoder word, valid flag and error flag          |
// |   in_haserr                                                                |
// |   out_valid/out_ready/    FIFO head handshake and data                     |
// |   out_data                                                                 |
// |   fifo_level              number of stored words                           |
// |   err_cnt, ovf_cnt        saturating errored-word / overflow-drop counts   |
// |   burst_alarm             sticky flag: a retry burst has occurred          |
// |   retry_req               one-cycle retransmit request                     |
// |   clr_stats               synchronous clear of counters and burst_alarm    |
// +----------------------------------------------------------------------------+
module crc_64_rx_buf #(
   parameter int DEPTH     = 4,
   parameter int CNT_W     = 16,
   parameter int ERR_BURST = 3
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   input  logic [0:63]              in_data,
   input  logic                     in_haserr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [0:63]              out_data,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [CNT_W-1:0]         err_cnt,
   output logic [CNT_W-1:0]         ovf_cnt,
   output logic                     burst_alarm,
   output logic                     retry_req,
   input  logic                     clr_stats
);

   localparam int c_addr_w = $clog2(DEPTH);
   localparam int c_ptr_w  = c_addr_w + 1;
   localparam int c_run_w  = $clog2(ERR_BURST + 1);

   localparam logic [c_ptr_w-1:0] c_depth      = c_ptr_w'(DEPTH);
   localparam logic [CNT_W-1:0]   c_cnt_max    = '1;
   localparam logic [c_run_w-1:0] c_run_one    = c_run_w'(1);
   localparam logic [c_run_w-1:0] c_burst_full = c_run_w'(ERR_BURST);
   localparam logic [c_run_w-1:0] c_burst_last = c_run_w'(ERR_BURST - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_ALARM = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // FIFO storage and pointers
   // ------------------------------------------------------------------------
   logic [0:63]          r_mem [DEPTH];
   logic [c_ptr_w-1:0]   r_wr_ptr;
   logic [c_ptr_w-1:0]   r_rd_ptr;

   logic [c_ptr_w-1:0]   w_level;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_pop;
   logic                 w_good;
   logic                 w_push;
   logic                 w_drop;
   logic                 w_err;

   // Pointers carry one extra bit so that equal low bits with differing MSBs
   // reads as full; the modulo-2*DEPTH difference is the fill level.
   assign w_level = r_wr_ptr - r_rd_ptr;
   assign w_full  = (w_level == c_depth);
   assign w_empty = (w_level == '0);

   assign w_pop   = ~w_empty & out_ready;
   assign w_good  = in_valid & ~in_haserr;
   assign w_err   = in_valid & in_haserr;
   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign w_push  = w_good & (~w_full | w_pop);
   assign w_drop  = w_good & w_full & ~w_pop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push) begin
         r_mem[r_wr_ptr[c_addr_w-1:0]] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   // Head is read straight out of registered storage; memory is cleared on
   // reset so the head reads zero while nothing has been written.
   assign out_data   = r_mem[r_rd_ptr[c_addr_w-1:0]];
   assign out_valid  = ~w_empty;
   assign fifo_level = w_level;

   // ------------------------------------------------------------------------
   // Statistics counters (saturating, clear has priority)
   // ------------------------------------------------------------------------
   logic [CNT_W-1:0] r_err_cnt;
   logic [CNT_W-1:0] r_ovf_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_err_cnt <= '0;
         r_ovf_cnt <= '0;
      end else if (clr_stats) begin
         r_err_cnt <= '0;
         r_ovf_cnt <= '0;
      end else begin
         if (w_err && (r_err_cnt != c_cnt_max)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
         end
         if (w_drop && (r_ovf_cnt != c_cnt_max)) begin
            r_ovf_cnt <= r_ovf_cnt + 1'b1;
         end
      end
   end

   assign err_cnt = r_err_cnt;
   assign ovf_cnt = r_ovf_cnt;

   // ------------------------------------------------------------------------
   // Burst detector FSM
   // ------------------------------------------------------------------------
   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_run_w-1:0]   r_run_cnt;
   logic [c_run_w-1:0]   w_run_cnt_nxt;
   logic                 w_enter_alarm;
   logic                 r_retry_req;
   logic                 r_burst_alarm;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_run_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_run_cnt <= w_run_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_run_cnt_nxt = r_run_cnt;
      w_enter_alarm = 1'b0;
      if (in_valid) begin
         if (in_haserr) begin
            case (r_state)
               S_IDLE: begin
                  if (ERR_BURST == 1) begin
                     w_state_nxt   = S_ALARM;
                     w_run_cnt_nxt = c_burst_full;
                     w_enter_alarm = 1'b1;
                  end else begin
                     w_state_nxt   = S_RUN;
                     w_run_cnt_nxt = c_run_one;
                  end
               end
               S_RUN: begin
                  if (r_run_cnt == c_burst_last) begin
                     w_state_nxt   = S_ALARM;
                     w_run_cnt_nxt = c_burst_full;
                     w_enter_alarm = 1'b1;
                  end else begin
                     w_run_cnt_nxt = r_run_cnt + 1'b1;
                  end
               end
               S_ALARM: begin
                  // Continuing errors hold the alarm without a new pulse.
                  w_state_nxt   = S_ALARM;
               end
               default: begin
                  w_state_nxt   = S_IDLE;
                  w_run_cnt_nxt = '0;
               end
            endcase
         end else begin
            w_state_nxt   = S_IDLE;
            w_run_cnt_nxt = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_retry_req   <= 1'b0;
         r_burst_alarm <= 1'b0;
      end else begin
         r_retry_req <= w_enter_alarm;
         if (clr_stats) begin
            r_burst_alarm <= 1'b0;
         end else if (w_enter_alarm) begin
            r_burst_alarm <= 1'b1;
         end
      end
   end

   assign retry_req   = r_retry_req;
   assign burst_alarm = r_burst_alarm;

endmodule
`default_nettype wire

// File: tb/tb_crc_64_rx_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_crc_64_rx_buf                                             |
// | Description : Directed self-checking bench for crc_64_rx_buf. A queue holds|
// |               the words expected at the FIFO head; counters, alarm and     |
// |               retry pulse come from a small reference model.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_crc_64_rx_buf;

   localparam int c_depth = 4;

   logic          clk;
   logic          reset_n;
   logic          in_valid;
   logic [0:63]   in_data;
   logic          in_haserr;
   logic          out_ready;
   logic          clr_stats;

   logic          out_valid;
   logic [0:63]   out_data;
   logic [2:0]    fifo_level;
   logic [15:0]   err_cnt;
   logic [15:0]   ovf_cnt;
   logic          burst_alarm;
   logic          retry_req;

   logic          out_valid_4;
   logic [0:63]   out_data_4;
   logic [2:0]    fifo_level_4;
   logic [3:0]    err_cnt_4;
   logic [3:0]    ovf_cnt_4;
   logic          burst_alarm_4;
   logic          retry_req_4;

   crc_64_rx_buf #(.DEPTH(4), .CNT_W(16), .ERR_BURST(3)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_data(in_data), .in_haserr(in_haserr),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .fifo_level(fifo_level), .err_cnt(err_cnt), .ovf_cnt(ovf_cnt),
      .burst_alarm(burst_alarm), .retry_req(retry_req), .clr_stats(clr_stats)
   );

   crc_64_rx_buf #(.DEPTH(4), .CNT_W(4), .ERR_BURST(3)) dut4 (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_data(in_data), .in_haserr(in_haserr),
      .out_valid(out_valid_4), .out_ready(out_ready), .out_data(out_data_4),
      .fifo_level(fifo_level_4), .err_cnt(err_cnt_4), .ovf_cnt(ovf_cnt_4),
      .burst_alarm(burst_alarm_4), .retry_req(retry_req_4), .clr_stats(clr_stats)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [63:0] q[$];
   int          exp_err;
   int          exp_err4;
   int          exp_ovf;
   bit          exp_alarm;
   bit          exp_retry;
   int          m_run;

   int          n_checks;
   int          n_fail;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      exp_err   = 0;
      exp_err4  = 0;
      exp_ovf   = 0;
      exp_alarm = 1'b0;
      exp_retry = 1'b0;
      m_run     = 0;
   endtask

   task automatic model_step(input bit v, input logic [63:0] d, input bit e,
                             input bit rdy, input bit clr);
      bit pop, full, good, push, drop;
      pop  = (q.size() != 0) && rdy;
      full = (q.size() == c_depth);
      good = v && !e;
      push = good && (!full || pop);
      drop = good && full && !pop;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(d);
      exp_retry = 1'b0;
      if (v) begin
         if (e) begin
            m_run++;
            if (m_run == 3) exp_retry = 1'b1;
         end else begin
            m_run = 0;
         end
      end
      if (clr) begin
         exp_err   = 0;
         exp_err4  = 0;
         exp_ovf   = 0;
         exp_alarm = 1'b0;
      end else begin
         if (v && e) begin
            if (exp_err  < 65535) exp_err++;
            if (exp_err4 < 15)    exp_err4++;
         end
         if (drop && exp_ovf < 65535) exp_ovf++;
         if (exp_retry) exp_alarm = 1'b1;
      end
   endtask

   task automatic check_all();
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (q.size() != 0) chk("out_data", out_data, q[0]);
      chk("fifo_level", 64'(fifo_level), 64'(q.size()));
      chk("err_cnt", 64'(err_cnt), 64'(exp_err));
      chk("ovf_cnt", 64'(ovf_cnt), 64'(exp_ovf));
      chk("burst_alarm", 64'(burst_alarm), 64'(exp_alarm));
      chk("retry_req", 64'(retry_req), 64'(exp_retry));
      chk("err_cnt_w4", 64'(err_cnt_4), 64'(exp_err4));
   endtask

   // Drive one cycle of inputs, then predict and compare just after the edge.
   task automatic step(input bit v, input logic [63:0] d, input bit e,
                       input bit rdy, input bit clr);
      in_valid  = v;
      in_data   = d;
      in_haserr = e;
      out_ready = rdy;
      clr_stats = clr;
      @(posedge clk);
      #1;
      model_step(v, d, e, rdy, clr);
      check_all();
   endtask

   initial begin
      logic [63:0] w;
      n_checks  = 0;
      n_fail    = 0;
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_haserr = 1'b0;
      out_ready = 1'b0;
      clr_stats = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all();
      chk("reset_out_data", out_data, 64'h0);
      reset_n = 1'b1;

      // Fill to full, then overflow one word.
      for (int i = 0; i < 4; i++) step(1, 64'hA0A0_0000_0000_0000 | 64'(i), 0, 0, 0);
      step(1, 64'hA0A0_0000_0000_0004, 0, 0, 0);
      // Drain: four words on consecutive cycles, then empty.
      for (int i = 0; i < 5; i++) step(0, 64'h0, 0, 1, 0);

      // Refill, then push and pop together at full, then stream through wrap.
      for (int i = 0; i < 4; i++) step(1, 64'hB0B0_0000_0000_0000 | 64'(i), 0, 0, 0);
      step(1, 64'hB0B0_0000_0000_00FF, 0, 1, 0);
      for (int i = 0; i < 20; i++) begin
         w = {$urandom, $urandom};
         step(1, w, 0, 1, 0);
      end
      for (int i = 0; i < 5; i++) step(0, 64'h0, 0, 1, 0);

      // Error pattern E,E,G,E,E,E then 2 more E, then G and E,E,E.
      step(1, 64'hEEEE_0000_0000_0001, 1, 1, 0);
      step(1, 64'hEEEE_0000_0000_0002, 1, 1, 0);
      step(1, 64'hC0C0_0000_0000_0001, 0, 1, 0);
      for (int i = 0; i < 5; i++) step(1, 64'hEEEE_0000_0000_0010 | 64'(i), 1, 1, 0);
      step(0, 64'hEEEE_0000_0000_00AA, 1, 1, 0);   // ignored: not valid
      step(1, 64'hC0C0_0000_0000_0002, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 64'hEEEE_0000_0000_0020 | 64'(i), 1, 0, 0);
      step(0, 64'h0, 0, 1, 0);
      step(0, 64'h0, 0, 1, 0);

      // Saturation of the 4-bit instance, then clear alongside an errored word.
      for (int i = 0; i < 20; i++) step(1, 64'hEEEE_0000_0000_0100 | 64'(i), 1, 1, 0);
      step(1, 64'hEEEE_0000_0000_0200, 1, 1, 1);
      step(1, 64'hEEEE_0000_0000_0201, 1, 1, 0);

      // Three words buffered and FSM in RUN, then asynchronous reset.
      step(1, 64'hC0C0_0000_0000_0010, 0, 0, 0);
      step(1, 64'hC0C0_0000_0000_0011, 0, 0, 0);
      step(1, 64'hC0C0_0000_0000_0012, 0, 0, 0);
      step(1, 64'hEEEE_0000_0000_0300, 1, 0, 0);
      in_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("rst_mid_out_data", out_data, 64'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step(1, 64'hEEEE_0000_0000_0400, 1, 1, 0);
      step(1, 64'hEEEE_0000_0000_0401, 1, 1, 0);
      step(1, 64'hEEEE_0000_0000_0402, 1, 1, 0);
      step(0, 64'h0, 0, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/crc_64_rx_buf.md
# crc_64_rx_buf

Receive-side buffer and error monitor that sits directly downstream of the 70-bit CRC-6 codeword decoder. Each cycle it takes the decoder's 64-bit data word, valid flag and error flag. Error-free words go into a small first-word-fall-through FIFO with a valid/ready output handshake. Errored words are discarded and counted, and a run of consecutive errored words raises a one-cycle retransmit request to the link controller.

## Interface
Parameters:
- DEPTH, 4, FIFO depth in words; power of two, >= 2
- CNT_W, 16, width of the statistics counters
- ERR_BURST, 3, number of consecutive errored words that triggers a retry; >= 1

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  decoder output word is valid this cycle
- in_data  input  [0:63]  decoded data word
- in_haserr  input  1  non-zero syndrome for this word
- out_valid  output  1  FIFO head is valid
- out_ready  input  1  consumer accepts the head this cycle
- out_data  output  [0:63]  FIFO head word
- fifo_level  output  $clog2(DEPTH)+1  number of stored words
- err_cnt  output  CNT_W  errored words received; saturating
- ovf_cnt  output  CNT_W  good words dropped because the FIFO was full; saturating
- burst_alarm  output  1  sticky: a retry burst has occurred since the last clear
- retry_req  output  1  single-cycle retransmit request pulse
- clr_stats  input  1  synchronous clear of err_cnt, ovf_cnt and burst_alarm

## Operation
- A word is accepted only when in_valid=1. When in_valid=0, in_data and in_haserr are ignored.
- Good word (in_haserr=0):
  - Pushed when the FIFO is not full, or when it is full and a pop occurs in the same cycle (out_valid & out_ready).
  - Otherwise dropped, and ovf_cnt increments.
- Errored word (in_haserr=1): never pushed; err_cnt increments.
- FIFO:
  - Circular buffer with rd/wr pointers of $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty.
  - Pointers wrap modulo 2*DEPTH.
  - out_valid = (level != 0); out_data = mem[rd_ptr]. The head is registered storage, not a bypass.
  - Pop occurs on out_valid & out_ready. out_ready while empty has no effect.
  - Simultaneous push and pop leaves the level unchanged, at any level including full.
- Counters saturate at 2^CNT_W-1 and never wrap.
- clr_stats:
  - Has priority over an increment in the same cycle; that event is not counted.
  - Does not affect the FIFO or the burst FSM.
- Burst FSM, with run counter run_cnt:
  - IDLE: an errored word sets run_cnt=1. If ERR_BURST==1, go to ALARM instead.
  - RUN: an errored word increments run_cnt; on reaching ERR_BURST, go to ALARM. A good valid word clears run_cnt and returns to IDLE.
  - ALARM: entering ALARM asserts retry_req for exactly one cycle and sets burst_alarm. Further errored words hold ALARM with no new pulse. A good valid word returns to IDLE with run_cnt=0.
  - Cycles with in_valid=0 do not change the FSM.
- Reset, asynchronous:
  - FIFO empty; out_valid=0; out_data=0; fifo_level=0.
  - err_cnt=0; ovf_cnt=0; burst_alarm=0; retry_req=0.
  - FSM in IDLE with run_cnt=0.
  - Reset mid-operation discards all stored words immediately.

## Timing
- Push latency 1: a word accepted in cycle N appears at out_data with out_valid=1 in cycle N+1 when the FIFO was empty.
- Pop: the head advances in the cycle after the out_valid & out_ready edge. out_valid may stay high with the next word at full throughput, one word per cycle.
- fifo_level, err_cnt and ovf_cnt reflect cycle-N events in cycle N+1.
- retry_req is high in cycle N+1, where cycle N carries the ERR_BURST-th consecutive errored word. burst_alarm rises in the same cycle.
- All outputs are registered. There is no combinational path from in_* to out_*. out_valid does not depend combinationally on out_ready.

## Test plan
- After reset, push 4 good words A0..A3 with out_ready=0 -> fifo_level=4, out_data=A0. Push A4 -> ovf_cnt=1, fifo_level stays 4. Then hold out_ready=1 -> A0..A3 emerge in order on 4 consecutive cycles, then out_valid=0.
- FIFO full, with push and pop in the same cycle -> the pushed word is stored, level stays 4, ovf_cnt unchanged. Stream 20 words with out_ready=1 to exercise pointer wrap; output order matches input order.
- Errored words E,E,good,E,E,E (ERR_BURST=3) -> err_cnt=5; exactly one retry_req pulse, one cycle after the 3rd consecutive E; burst_alarm=1; no errored data appears at out_data.
- In ALARM, 2 more errored words -> no extra retry_req. Then a good word followed by 3 errored words -> a second single retry_req pulse.
- CNT_W=4: send 20 errored words -> err_cnt saturates at 15. Assert clr_stats together with an errored word -> err_cnt=0, burst_alarm=0.
- Assert reset_n low with 3 words buffered and the FSM in RUN -> out_valid=0, fifo_level=0, all counters 0 immediately. The first errored word after release gives run_cnt=1 with no pulse.
